// File: rtl/median_pkg.sv
// Shared types and constants for the median filter front end.
//   feeder_state_t : window feeder FSM states
//   NTAPS          : samples per median burst (3x3 window)
//   KW             : width of the burst sample counter
package median_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT
  } feeder_state_t;

  localparam int unsigned NTAPS = 9;
  localparam int unsigned KW    = 4;

endpackage

// File: rtl/line_buffer.sv
// Single-port row buffer: synchronous write, combinational read at the same
// address, so a write in the same cycle returns the old (read-before-write) entry.
// Ports:
//   CLK   : clock
//   we    : write enable
//   addr  : read/write address (column)
//   wdata : data written on we
//   rdata : current contents at addr
module line_buffer
  import median_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             CLK,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  // Contents are never reset; window validity is tracked by position only.
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/median_window_feeder.sv
// Raster-to-window feeder for the 9-input median block. Buffers two rows,
// builds a 3x3 window per accepted pixel and, for interior pixels, sends the
// window row-major as a 9-cycle DSI burst, then waits for the median DSO.
// Ports:
//   CLK, nRST : clock, asynchronous active-low reset
//   PI/PVALID : raster pixel and its valid
//   PREADY    : feeder accepts PI this cycle
//   MED_DI    : serial window sample to the median block (0 when idle)
//   MED_DSI   : window burst strobe
//   MED_DSO   : median result pulse
module median_window_feeder
  import median_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IMG_W = 16,
  parameter int unsigned IMG_H = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [WIDTH-1:0] PI,
  input  logic             PVALID,
  output logic             PREADY,
  output logic [WIDTH-1:0] MED_DI,
  output logic             MED_DSI,
  input  logic             MED_DSO
);

  localparam int unsigned XW = $clog2(IMG_W);
  localparam int unsigned YW = $clog2(IMG_H);

  logic [XW-1:0]    x_q;
  logic [YW-1:0]    y_q;
  feeder_state_t    state_q;
  logic [KW-1:0]    k_q;
  logic [KW-1:0]    k_inc;
  logic             pready_q;
  logic             dsi_q;
  logic [WIDTH-1:0] di_q;
  logic [WIDTH-1:0] win_q [NTAPS];
  logic [WIDTH-1:0] win_d [NTAPS];
  logic [WIDTH-1:0] lb0_rd;
  logic [WIDTH-1:0] lb1_rd;
  logic             xfer;
  logic             win_done;
  logic             last_x;
  logic             last_y;

  assign xfer     = PVALID && pready_q;
  assign win_done = (x_q >= XW'(2)) && (y_q >= YW'(2));
  assign last_x   = (x_q == XW'(IMG_W - 1));
  assign last_y   = (y_q == YW'(IMG_H - 1));
  assign k_inc    = k_q + KW'(1);

  assign PREADY  = pready_q;
  assign MED_DSI = dsi_q;
  assign MED_DI  = di_q;

  // lb0 holds row y-1, lb1 holds row y-2; both shift down one row per write.
  line_buffer #(
    .WIDTH(WIDTH),
    .DEPTH(IMG_W),
    .AW   (XW)
  ) lb0 (
    .CLK  (CLK),
    .we   (xfer),
    .addr (x_q),
    .wdata(PI),
    .rdata(lb0_rd)
  );

  line_buffer #(
    .WIDTH(WIDTH),
    .DEPTH(IMG_W),
    .AW   (XW)
  ) lb1 (
    .CLK  (CLK),
    .we   (xfer),
    .addr (x_q),
    .wdata(lb0_rd),
    .rdata(lb1_rd)
  );

  // Window shifted left by one column with the new column entering on the right.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      win_d[3*r]     = win_q[3*r+1];
      win_d[3*r + 1] = win_q[3*r+2];
    end
    win_d[2] = lb1_rd;
    win_d[5] = lb0_rd;
    win_d[8] = PI;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < int'(NTAPS); i++) begin
        win_q[i] <= '0;
      end
    end else if (xfer) begin
      win_q <= win_d;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      x_q <= '0;
      y_q <= '0;
    end else if (xfer) begin
      if (last_x) begin
        x_q <= '0;
        y_q <= last_y ? '0 : y_q + YW'(1);
      end else begin
        x_q <= x_q + XW'(1);
      end
    end
  end

  // PREADY is registered so it reads 0 throughout reset.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      k_q      <= '0;
      pready_q <= 1'b0;
      dsi_q    <= 1'b0;
      di_q     <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          pready_q <= 1'b1;
          if (xfer && win_done) begin
            state_q  <= SEND;
            pready_q <= 1'b0;
            k_q      <= '0;
            dsi_q    <= 1'b1;
            // win_q updates on this same edge, so take sample 0 from win_d.
            di_q     <= win_d[0];
          end
        end
        SEND: begin
          if (k_q == KW'(NTAPS - 1)) begin
            state_q <= WAIT;
            dsi_q   <= 1'b0;
            di_q    <= '0;
          end else begin
            k_q  <= k_inc;
            di_q <= win_q[k_inc];
          end
        end
        WAIT: begin
          if (MED_DSO) begin
            state_q  <= IDLE;
            pready_q <= 1'b1;
            k_q      <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
